// File: rtl/cve2_bus_arbiter_pkg.sv
// Shared types for the instruction/data memory-port arbiter.
package cve2_bus_arbiter_pkg;

  typedef enum logic {BUS_OWNER_INSTR, BUS_OWNER_DATA} bus_owner_e;
  typedef enum logic {BUS_ARB, BUS_HOLD} bus_arb_state_e;

  // Instruction fetches are always full-word reads.
  localparam logic [3:0] INSTR_BE = 4'b1111;

endpackage

// File: rtl/cve2_bus_owner_fifo.sv
// Small in-order FIFO remembering which requester owns each granted,
// not-yet-answered transaction on the shared memory port.
module cve2_bus_owner_fifo
  import cve2_bus_arbiter_pkg::*;
#(
  parameter int unsigned Depth = 2
) (
  input  logic                           clk_i,
  input  logic                           rst_ni,
  input  logic                           push_i,
  input  bus_owner_e                     push_owner_i,
  input  logic                           pop_i,
  output bus_owner_e                     head_o,
  output logic [$clog2(Depth+1)-1:0]     count_o
);

  localparam int unsigned CntW = $clog2(Depth + 1);
  localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;
  localparam logic [PtrW-1:0] LastPtr = PtrW'(Depth - 1);
  localparam logic [CntW-1:0] FullCnt = CntW'(Depth);

  bus_owner_e      mem_q [Depth];
  bus_owner_e      mem_d [Depth];
  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0] count_q, count_d;
  logic            push_ok, pop_ok;

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (p == LastPtr) ? '0 : p + 1'b1;
  endfunction

  // A pop in the same cycle makes room, so push at full is accepted then.
  assign pop_ok  = pop_i && (count_q != '0);
  assign push_ok = push_i && ((count_q != FullCnt) || pop_ok);

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) begin
      mem_d[wr_ptr_q] = push_owner_i;
      wr_ptr_d        = ptr_inc(wr_ptr_q);
    end
    if (pop_ok) begin
      rd_ptr_d = ptr_inc(rd_ptr_q);
    end
    if (push_ok && !pop_ok) begin
      count_d = count_q + 1'b1;
    end else if (pop_ok && !push_ok) begin
      count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < Depth; i++) begin
        mem_q[i] <= BUS_OWNER_INSTR;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign head_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

  push_when_full_a: assert property (@(posedge clk_i) disable iff (!rst_ni) push_i |-> push_ok);
  pop_when_empty_a: assert property (@(posedge clk_i) disable iff (!rst_ni) pop_i |-> pop_ok);

endmodule

// File: rtl/cve2_bus_arbiter.sv
// Shares one OBI-style memory port between instruction fetch and LSU:
// data-first priority with an instr anti-starvation limit, held until grant.
module cve2_bus_arbiter
  import cve2_bus_arbiter_pkg::*;
#(
  parameter int unsigned MaxOutstanding = 2,
  parameter int unsigned StarveLimit    = 4
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        instr_req_i,
  input  logic [31:0] instr_addr_i,
  input  logic        data_req_i,
  input  logic [31:0] data_addr_i,
  input  logic        data_we_i,
  input  logic [3:0]  data_be_i,
  input  logic [31:0] data_wdata_i,
  output logic        instr_gnt_o,
  output logic        data_gnt_o,
  output logic        instr_rvalid_o,
  output logic        data_rvalid_o,
  output logic [31:0] instr_rdata_o,
  output logic [31:0] data_rdata_o,
  output logic        instr_err_o,
  output logic        data_err_o,
  output logic        mem_req_o,
  output logic [31:0] mem_addr_o,
  output logic        mem_we_o,
  output logic [3:0]  mem_be_o,
  output logic [31:0] mem_wdata_o,
  input  logic        mem_gnt_i,
  input  logic        mem_rvalid_i,
  input  logic [31:0] mem_rdata_i,
  input  logic        mem_err_i,
  output logic        resp_orphan_o
);

  localparam int unsigned CntW = $clog2(MaxOutstanding + 1);
  localparam logic [CntW-1:0] MaxCnt = CntW'(MaxOutstanding);
  localparam logic [3:0] StarveMax = 4'(StarveLimit);

  bus_arb_state_e  state_q, state_d;
  bus_owner_e      owner_q, owner_d;
  bus_owner_e      sel, fifo_head;
  logic [3:0]      starve_q, starve_d;
  logic [CntW-1:0] count;
  logic            sel_req, can_issue, sel_data, rsp_valid;

  // HOLD pins the latched owner; otherwise data wins unless instr has starved.
  always_comb begin
    sel = BUS_OWNER_INSTR;
    if (state_q == BUS_HOLD) begin
      sel = owner_q;
    end else if ((starve_q == StarveMax) && instr_req_i) begin
      sel = BUS_OWNER_INSTR;
    end else if (data_req_i) begin
      sel = BUS_OWNER_DATA;
    end
  end

  assign sel_data  = (sel == BUS_OWNER_DATA);
  assign sel_req   = sel_data ? data_req_i : instr_req_i;
  assign can_issue = (count < MaxCnt);
  assign mem_req_o = sel_req && can_issue;

  assign mem_addr_o  = !mem_req_o ? 32'h0 : (sel_data ? data_addr_i : instr_addr_i);
  assign mem_we_o    = mem_req_o && sel_data && data_we_i;
  assign mem_be_o    = !mem_req_o ? 4'h0 : (sel_data ? data_be_i : INSTR_BE);
  assign mem_wdata_o = (mem_req_o && sel_data) ? data_wdata_i : 32'h0;

  assign instr_gnt_o = mem_gnt_i && mem_req_o && !sel_data;
  assign data_gnt_o  = mem_gnt_i && mem_req_o && sel_data;

  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    starve_d = starve_q;
    if (state_q == BUS_ARB) begin
      if (mem_req_o && !mem_gnt_i) begin
        state_d = BUS_HOLD;
        owner_d = sel;
      end
    end else if (mem_gnt_i) begin
      state_d = BUS_ARB;
    end
    // Counts only cycles where data actually took the port from instr.
    if (!instr_req_i || instr_gnt_o) begin
      starve_d = 4'h0;
    end else if (sel_data && can_issue && (starve_q != StarveMax)) begin
      starve_d = starve_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= BUS_ARB;
      owner_q  <= BUS_OWNER_INSTR;
      starve_q <= 4'h0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      starve_q <= starve_d;
    end
  end

  cve2_bus_owner_fifo #(
    .Depth (MaxOutstanding)
  ) u_owner_fifo (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .push_i       (instr_gnt_o || data_gnt_o),
    .push_owner_i (sel),
    .pop_i        (rsp_valid),
    .head_o       (fifo_head),
    .count_o      (count)
  );

  assign rsp_valid      = mem_rvalid_i && (count != '0);
  assign resp_orphan_o  = mem_rvalid_i && (count == '0);
  assign instr_rvalid_o = rsp_valid && (fifo_head == BUS_OWNER_INSTR);
  assign data_rvalid_o  = rsp_valid && (fifo_head == BUS_OWNER_DATA);

  assign instr_rdata_o = mem_rdata_i;
  assign data_rdata_o  = mem_rdata_i;
  assign instr_err_o   = mem_err_i;
  assign data_err_o    = mem_err_i;

endmodule
